// File: rtl/gcd_req_driver.sv
// Self-test request driver for the GCD unit. It streams operand pairs from a vector
// memory over a val/rdy channel and checks the in-order responses against stored results.
module gcd_req_driver #(
  parameter int  NUM_VECTORS    = 100,
  parameter int  MAX_INFLIGHT   = 2,
  parameter int  TIMEOUT_CYCLES = 4096,
  localparam int AW             = $clog2(NUM_VECTORS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [47:0]   wr_data,
  input  logic          start,
  output logic          req_val,
  input  logic          req_rdy,
  output logic [31:0]   req_msg,
  input  logic          resp_val,
  output logic          resp_rdy,
  input  logic [15:0]   resp_msg,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [15:0]   err_count,
  output logic [AW-1:0] first_err_idx
);
  localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW:0] NV      = (AW+1)'(NUM_VECTORS);
  localparam logic [AW:0] LAST    = (AW+1)'(NUM_VECTORS - 1);
  localparam logic [2:0]  MAXI    = 3'(MAX_INFLIGHT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [47:0]     mem [NUM_VECTORS];
  logic [AW:0]     send_idx, recv_idx;
  logic [AW-1:0]   send_addr, recv_addr;
  logic [2:0]      inflight;
  logic [TW-1:0]   to_cnt;
  logic [15:0]     resp_exp;
  logic [15:0]     err_nxt;
  logic            req_fire, resp_fire, mismatch, last_resp, to_hit, in_run;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Index-to-address with a safe fallback once an index has run past the last vector
  assign send_addr = (send_idx < NV) ? send_idx[AW-1:0] : '0;
  assign recv_addr = (recv_idx < NV) ? recv_idx[AW-1:0] : '0;
  assign resp_exp  = mem[recv_addr][47:32];

  assign in_run    = (state == RUN);
  assign req_fire  = req_val && req_rdy;
  assign resp_fire = resp_val && resp_rdy;
  assign mismatch  = resp_fire && (resp_msg != resp_exp);
  assign err_nxt   = mismatch ? sat_inc16(err_count) : err_count;
  assign last_resp = resp_fire && (recv_idx == LAST);
  assign to_hit    = in_run && (inflight != 3'd0) && !resp_fire && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_val   = 1'b0;
    resp_rdy  = 1'b0;
    req_msg   = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy     = 1'b1;
        req_val  = (send_idx < NV) && (inflight < MAXI);
        resp_rdy = (inflight != 3'd0);
        if (req_val) req_msg = mem[send_addr][31:0];
        if (last_resp || to_hit) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Vector memory: writable only while no run is in progress; never cleared
  always_ff @(posedge clk) begin
    if (wr_en && !in_run && ({1'b0, wr_addr} < NV))
      mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      send_idx      <= '0;
      recv_idx      <= '0;
      inflight      <= '0;
      to_cnt        <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
    end else if (!in_run) begin
      if (start) begin
        send_idx      <= '0;
        recv_idx      <= '0;
        inflight      <= '0;
        to_cnt        <= '0;
        err_count     <= '0;
        first_err_idx <= '0;
        pass          <= 1'b0;
        timeout       <= 1'b0;
      end
    end else begin
      if (req_fire) send_idx <= send_idx + 1'b1;

      if (resp_fire) begin
        recv_idx  <= recv_idx + 1'b1;
        err_count <= err_nxt;
        if (mismatch && (err_count == 16'd0))
          first_err_idx <= recv_idx[AW-1:0];
      end

      case ({req_fire, resp_fire})
        2'b10:   inflight <= inflight + 3'd1;
        2'b01:   inflight <= inflight - 3'd1;
        default: inflight <= inflight;
      endcase

      // Idle-wait counter only runs while the unit owes us an answer
      if (resp_fire || (inflight == 3'd0)) to_cnt <= '0;
      else                                 to_cnt <= to_cnt + 1'b1;

      if (last_resp) pass <= (err_nxt == 16'd0);
      if (to_hit) begin
        timeout <= 1'b1;
        pass    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gcd_req_driver.sv
// Bench for gcd_req_driver: a delayed in-order GCD responder, a transaction-level
// model checked every cycle, and directed scenarios with literal expectations.
module tb_gcd_req_driver;
  localparam int NV   = 3;
  localparam int MAXI = 2;
  localparam int TOC  = 16;
  localparam int AW   = $clog2(NV);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [47:0]   wr_data = '0;
  logic          start = 1'b0;
  logic          req_rdy = 1'b1;
  logic          resp_val = 1'b0;
  logic [15:0]   resp_msg = '0;
  logic          req_val, resp_rdy, busy, done, pass, timeout;
  logic [31:0]   req_msg;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_idx;

  always #5 clk = ~clk;

  gcd_req_driver #(.NUM_VECTORS(NV), .MAX_INFLIGHT(MAXI), .TIMEOUT_CYCLES(TOC)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_idx(first_err_idx)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] gcd16(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, t;
    x = a;
    y = b;
    while (y != 16'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Environment: in-order GCD responder with a programmable delay, plus a fire log
  typedef struct { logic [15:0] val; int due; } pend_t;
  pend_t       pq[$];
  logic [31:0] fire_msg[$];
  int          fire_cyc[$];
  int          cyc = 0;
  int          resp_delay = 1;
  bit          resp_en = 1'b1;
  int          outst = 0, max_out = 0, both_cnt = 0;

  always @(posedge clk) begin
    if (reset || start) begin
      pq.delete();
      fire_msg.delete();
      fire_cyc.delete();
      outst = 0;
      max_out = 0;
      both_cnt = 0;
    end else begin
      if (resp_val && resp_rdy) begin
        void'(pq.pop_front());
        outst--;
      end
      if (req_val && req_rdy) begin
        pq.push_back('{val: gcd16(req_msg[31:16], req_msg[15:0]), due: cyc + resp_delay});
        fire_msg.push_back(req_msg);
        fire_cyc.push_back(cyc + 1);
        outst++;
      end
      if (req_val && req_rdy && resp_val && resp_rdy) both_cnt++;
      if (outst > max_out) max_out = outst;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (resp_en && pq.size() > 0 && pq[0].due <= cyc) begin
      resp_val = 1'b1;
      resp_msg = pq[0].val;
    end else begin
      resp_val = 1'b0;
      resp_msg = 16'hDEAD;
    end
  end

  // Transaction-level model: counts of sent/received items instead of DUT registers
  typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;
  mstate_t       m_st = M_IDLE;
  logic [47:0]   m_mem [NV];
  int            m_sent = 0, m_recv = 0, m_quiet = 0;
  logic [15:0]   m_err = '0;
  logic [AW-1:0] m_first = '0;
  bit            m_pass = 1'b0, m_tmo = 1'b0;

  function automatic bit m_req_val();
    return (m_st == M_RUN) && (m_sent < NV) && ((m_sent - m_recv) < MAXI);
  endfunction

  function automatic bit m_resp_rdy();
    return (m_st == M_RUN) && (m_sent > m_recv);
  endfunction

  always @(posedge clk) begin : model
    bit rf, sf;
    int owed;
    if (reset) begin
      m_st = M_IDLE; m_sent = 0; m_recv = 0; m_quiet = 0;
      m_err = '0; m_first = '0; m_pass = 1'b0; m_tmo = 1'b0;
    end else if (m_st != M_RUN) begin
      if (wr_en && int'(wr_addr) < NV) m_mem[wr_addr] = wr_data;
      if (start) begin
        m_st = M_RUN; m_sent = 0; m_recv = 0; m_quiet = 0;
        m_err = '0; m_first = '0; m_pass = 1'b0; m_tmo = 1'b0;
      end
    end else begin
      rf = m_req_val() && req_rdy;
      sf = m_resp_rdy() && resp_val;
      owed = m_sent - m_recv;
      if (sf) begin
        if (resp_msg != m_mem[m_recv][47:32]) begin
          if (m_err == 16'd0) m_first = AW'(m_recv);
          if (m_err != 16'hFFFF) m_err++;
        end
        m_recv++;
        if (m_recv == NV) begin
          m_st = M_DONE;
          m_pass = (m_err == 16'd0);
        end
      end
      if (rf) m_sent++;
      if (sf || owed == 0) m_quiet = 0;
      else                 m_quiet++;
      if (m_quiet == TOC) begin
        m_st = M_DONE; m_tmo = 1'b1; m_pass = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", busy, m_st == M_RUN);
      chk("done", done, m_st == M_DONE);
      chk("pass", pass, m_pass);
      chk("timeout", timeout, m_tmo);
      chk("err_count", err_count, m_err);
      chk("first_err_idx", first_err_idx, m_first);
      chk("req_val", req_val, m_req_val());
      chk("resp_rdy", resp_rdy, m_resp_rdy());
      chk("req_msg", req_msg, m_req_val() ? m_mem[m_sent][31:0] : 32'h0);
    end
  end

  task automatic write_vec(input int idx, input logic [15:0] e, input logic [15:0] a,
                           input logic [15:0] b);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(idx); wr_data = {e, a, b};
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int at_cyc);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_reached"}, done, 1'b1);
    at_cyc = cyc;
  endtask

  initial begin
    int dc;
    int n;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_req_val", req_val, 1'b0);
    chk("rst_resp_rdy", resp_rdy, 1'b0);
    chk("rst_err_count", err_count, 16'd0);
    reset = 1'b0;

    // Three correct vectors, fast responder
    write_vec(0, 16'd5, 16'd15, 16'd5);
    write_vec(1, 16'd9, 16'd27, 16'd36);
    write_vec(2, 16'd1, 16'd17, 16'd13);
    pulse_start();
    wait_done("basic", 200, dc);
    chk("basic_nfires", fire_msg.size(), 3);
    chk("basic_msg0", fire_msg[0], 32'h000F0005);
    chk("basic_msg1", fire_msg[1], 32'h001B0024);
    chk("basic_msg2", fire_msg[2], 32'h0011000D);
    chk("basic_pass", pass, 1'b1);
    chk("basic_err", err_count, 16'd0);

    // Wrong expectation on vector 1
    write_vec(1, 16'd4, 16'd27, 16'd36);
    pulse_start();
    wait_done("mism", 200, dc);
    chk("mism_pass", pass, 1'b0);
    chk("mism_err", err_count, 16'd1);
    chk("mism_first", first_err_idx, 2'd1);
    write_vec(1, 16'd9, 16'd27, 16'd36);

    // Slow responder: inflight limit and simultaneous fires
    resp_delay = 10;
    pulse_start();
    wait_done("bp", 200, dc);
    chk("bp_max_inflight", max_out, 2);
    chk("bp_same_cycle_fire_seen", both_cnt > 0, 1'b1);
    chk("bp_pass", pass, 1'b1);

    // Responder silent: abort 16 edges after the first request fire
    resp_en = 1'b0;
    pulse_start();
    wait_done("tmo", 200, dc);
    chk("tmo_latency", dc - fire_cyc[0], 16);
    chk("tmo_flag", timeout, 1'b1);
    chk("tmo_pass", pass, 1'b0);
    resp_en = 1'b1;

    // Reset after two requests have gone out
    pulse_start();
    n = 0;
    while (fire_msg.size() < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_two_fires", fire_msg.size(), 2);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid_req_val", req_val, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_err", err_count, 16'd0);
    reset = 1'b0;
    pulse_start();
    wait_done("rerun", 200, dc);
    chk("rerun_nfires", fire_msg.size(), 3);
    chk("rerun_msg0", fire_msg[0], 32'h000F0005);
    chk("rerun_msg2", fire_msg[2], 32'h0011000D);
    chk("rerun_pass", pass, 1'b1);

    // Write during RUN must be ignored; write in DONE must take effect
    pulse_start();
    write_vec(0, 16'd25, 16'd100, 16'd75);
    wait_done("wgate", 200, dc);
    chk("wgate_msg0", fire_msg[0], 32'h000F0005);
    chk("wgate_pass", pass, 1'b1);
    write_vec(0, 16'd25, 16'd100, 16'd75);
    resp_delay = 1;
    pulse_start();
    wait_done("wnew", 200, dc);
    chk("wnew_msg0", fire_msg[0], 32'h0064004B);
    chk("wnew_pass", pass, 1'b1);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_req_driver.md
# gcd_req_driver

Synthesizable request-side driver for the GCD unit's latency-insensitive interface: it issues `req_msg` operand pairs from an internal vector memory through a val/rdy handshake and accepts `resp_msg` results on the return channel. Each result is checked in order against its stored expected value. The block sits opposite the GCD unit in on-chip self-test and FPGA bring-up configurations. It reports pass/fail, an error count and the first failing index.

## Interface
- `NUM_VECTORS`, 100: vector-memory depth. Address width is `AW = $clog2(NUM_VECTORS)`.
- `MAX_INFLIGHT`, 2: maximum requests accepted by the unit but not yet answered (1..7).
- `TIMEOUT_CYCLES`, 4096: cycles without a response, while requests are outstanding, before aborting.

- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  vector-memory write strobe.
- `wr_addr`  in  AW  write index.
- `wr_data`  in  48  vector word: [47:32] expected GCD, [31:16] operand a, [15:0] operand b.
- `start`  in  1  one-cycle pulse that begins a run.
- `req_val`  out  1  request valid.
- `req_rdy`  in  1  unit ready for a request.
- `req_msg`  out  32  {a, b} = word[31:0] of the current send index; 0 when `req_val`=0.
- `resp_val`  in  1  response valid.
- `resp_rdy`  out  1  driver ready for a response.
- `resp_msg`  in  16  GCD result.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid when `done`=1: no mismatches and no timeout.
- `timeout`  out  1  run aborted by the timeout.
- `err_count`  out  16  mismatch count; saturates at 16'hFFFF.
- `first_err_idx`  out  AW  index of the first mismatch; 0 if there is none.

## Operation
- Reset: state IDLE. `req_val`, `resp_rdy`, `busy`, `done`, `pass`, `timeout`, `err_count`, `first_err_idx` are all 0. Internal `send_idx`, `recv_idx`, `inflight` and the timeout counter are 0. Memory contents are not cleared.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on `start`.
  - RUN -> DONE when the final response is accepted, or on timeout.
  - DONE -> RUN on `start` (restart).
  - `start` in RUN is ignored.
- Entering RUN clears `send_idx`, `recv_idx`, `inflight`, `err_count`, `first_err_idx`, `pass`, `timeout` and the timeout counter.
- Memory writes take effect only in IDLE or DONE. `wr_en` in RUN is ignored. Writes with `wr_addr` >= `NUM_VECTORS` are ignored.
- Request side:
  - `req_val` = RUN and `send_idx` < `NUM_VECTORS` and `inflight` < `MAX_INFLIGHT`.
  - The request fires when `req_val` && `req_rdy`; `send_idx` then increments.
  - `req_val` never depends on `req_rdy` (no combinational path).
- Response side:
  - `resp_rdy` = RUN and `inflight` > 0.
  - The response fires when `resp_val` && `resp_rdy`. On fire, `resp_msg` is compared to word[47:32] of `recv_idx`, then `recv_idx` increments.
  - On a mismatch, `err_count` increments. If it was 0 before the increment, `first_err_idx` latches `recv_idx`.
- `inflight` +1 on a request fire only, -1 on a response fire only, unchanged when both fire in the same cycle.
- Responses are assumed in order. `resp_val` while `inflight`=0 is not accepted (`resp_rdy`=0).
- Completion: the response fire with `recv_idx` = `NUM_VECTORS`-1 moves the block to DONE. `pass` = (`err_count` after that compare == 0).
- Timeout:
  - The counter increments in RUN when `inflight` > 0 and no response fires. It clears on any response fire and whenever `inflight` = 0.
  - When the counter reaches `TIMEOUT_CYCLES`, the block goes to DONE with `timeout`=1 and `pass`=0.
- Reset asserted mid-run returns the block to the IDLE reset state within one edge. Outstanding transactions are abandoned.

## Timing
- `start` sampled at edge N puts the block in RUN from cycle N+1. `req_val` is high in cycle N+1 if `NUM_VECTORS` > 0.
- With `req_rdy`=1 continuously and `MAX_INFLIGHT` unreached, one request issues per cycle.
- Memory read is asynchronous. `req_msg` and the expected value are valid in the same cycle as the index.
- `done`, `pass`, `err_count` are registered. `done` rises the cycle after the final response fire.
- Outputs hold stable in DONE until the next `start` or `reset`.

## Test plan
- Directed single-vector checks:
  - Load 3 vectors {a=15,b=5,exp=5}, {a=27,b=36,exp=9}, {a=17,b=13,exp=1}. Connect a correct GCD model and pulse `start`.
  - Required: 3 req fires carrying `req_msg` = 32'h000F0005, 32'h001B0024, 32'h0011000D. Then `done`=1, `pass`=1, `err_count`=0.
- Mismatch capture:
  - Store exp=4 for vector 1 (correct value 9).
  - Required: `done`=1, `pass`=0, `err_count`=1, `first_err_idx`=1.
- Backpressure and inflight limit:
  - `MAX_INFLIGHT`=2, responses delayed 10 cycles.
  - Required: never more than 2 req fires without a resp fire. `req_val` drops while `inflight`=2. A same-cycle req and resp fire leaves `inflight` unchanged.
- Timeout:
  - `TIMEOUT_CYCLES`=16, responder never asserts `resp_val`.
  - Required: exactly 16 cycles after the first req fire, `done`=1, `timeout`=1, `pass`=0.
- Reset mid-run:
  - Assert `reset` after 2 of 3 req fires.
  - Required: next cycle `req_val`=0, `busy`=0, `err_count`=0, memory retained. A new `start` reruns all 3 vectors and passes.
- Write gating and restart:
  - Pulse `wr_en` during RUN altering vector 0.
  - Required: the run is unaffected. In DONE, a write followed by `start` uses the new value.
